// File: rtl/drive_mode_arbiter.sv
// Drive mode arbiter: grants one of manual / semi-auto / auto control of the
// moving_state command. A mode change passes through a stop-hold window. The
// granted command, plus sticky barrier place/destroy requests, is framed for
// a UART with a valid/ready handshake and a periodic refresh.
module drive_mode_arbiter #(
    parameter int SWITCH_HOLD = 4,
    parameter int REFRESH     = 1000
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_power,
    input  logic [1:0] i_mode_sel,
    input  logic [3:0] i_man_cmd,
    input  logic [3:0] i_semi_cmd,
    input  logic [3:0] i_auto_cmd,
    input  logic       i_semi_valid,
    input  logic       i_auto_valid,
    input  logic       i_place_req,
    input  logic       i_destroy_req,
    input  logic       i_tx_ready,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    output logic [1:0] o_active_mode,
    output logic [2:0] o_grant,
    output logic       o_switch_pending
);

    // state  | meaning
    // OFF    | engine unpowered, no grant, stop command
    // MANUAL | manual controller owns the command
    // SEMI   | semi-auto requester owns the command
    // AUTO   | auto requester owns the command
    // SWITCH | stop held for SWITCH_HOLD cycles before granting the target
    typedef enum logic [2:0] {
        ST_OFF,
        ST_MANUAL,
        ST_SEMI,
        ST_AUTO,
        ST_SWITCH
    } state_t;

    localparam logic [1:0]  MODE_MANUAL  = 2'b00;
    localparam logic [1:0]  MODE_RSVD    = 2'b11;
    localparam logic [7:0]  HOLD_LAST    = 8'(SWITCH_HOLD - 1);
    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH - 1);
    // A frame loaded on the edge where the idle counter reaches REFRESH-1
    // is accepted REFRESH cycles after the previous one.
    localparam logic [15:0] REFRESH_DUE  = 16'(REFRESH - 2);

    state_t      r_state;
    logic [1:0]  r_active_mode;
    logic [1:0]  r_target;
    logic [7:0]  r_hold_cnt;
    logic [2:0]  r_grant;
    logic        r_switch_pending;

    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic [3:0]  r_last_cmd;
    logic [15:0] r_refresh_cnt;
    logic        r_place_flag;
    logic        r_destroy_flag;

    logic [3:0]  w_cmd;
    logic        w_xfer;
    logic        w_build;
    logic        w_mode_req;
    logic        w_frame_place;

    function automatic state_t mode_to_state(input logic [1:0] m);
        case (m)
            2'b01:   return ST_SEMI;
            2'b10:   return ST_AUTO;
            default: return ST_MANUAL;
        endcase
    endfunction

    function automatic logic [2:0] mode_to_grant(input logic [1:0] m);
        case (m)
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // Command of the currently granted requester; stop whenever nobody owns it.
    always_comb begin
        w_cmd = 4'b0000;
        case (r_state)
            ST_MANUAL: w_cmd = i_man_cmd;
            ST_SEMI:   w_cmd = i_semi_valid ? i_semi_cmd : 4'b0000;
            ST_AUTO:   w_cmd = i_auto_valid ? i_auto_cmd : 4'b0000;
            default:   w_cmd = 4'b0000;
        endcase
    end

    assign w_mode_req = (i_mode_sel != MODE_RSVD);

    // Mode FSM with registered grant, active mode and switch flag.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= ST_OFF;
            r_active_mode    <= MODE_MANUAL;
            r_target         <= MODE_MANUAL;
            r_hold_cnt       <= '0;
            r_grant          <= 3'b000;
            r_switch_pending <= 1'b0;
        end else if (!i_power) begin
            r_state          <= ST_OFF;
            r_active_mode    <= MODE_MANUAL;
            r_target         <= MODE_MANUAL;
            r_hold_cnt       <= '0;
            r_grant          <= 3'b000;
            r_switch_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_state       <= ST_MANUAL;
                    r_active_mode <= MODE_MANUAL;
                    r_grant       <= 3'b001;
                end
                ST_MANUAL, ST_SEMI, ST_AUTO: begin
                    if (w_mode_req && (i_mode_sel != r_active_mode)) begin
                        r_state          <= ST_SWITCH;
                        r_target         <= i_mode_sel;
                        r_hold_cnt       <= '0;
                        r_grant          <= 3'b000;
                        r_switch_pending <= 1'b1;
                    end
                end
                ST_SWITCH: begin
                    // A new target (including a return to the source) restarts the hold.
                    if (w_mode_req && (i_mode_sel != r_target)) begin
                        r_target   <= i_mode_sel;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state          <= mode_to_state(r_target);
                        r_active_mode    <= r_target;
                        r_grant          <= mode_to_grant(r_target);
                        r_switch_pending <= 1'b0;
                        r_hold_cnt       <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state          <= ST_OFF;
                    r_grant          <= 3'b000;
                    r_switch_pending <= 1'b0;
                end
            endcase
        end
    end

    assign w_xfer        = r_tx_valid & i_tx_ready;
    // Destroy has priority; a pending place waits for the following frame.
    assign w_frame_place = r_place_flag & ~r_destroy_flag;
    assign w_build       = ~r_tx_valid &
                           ((w_cmd != r_last_cmd) | r_place_flag | r_destroy_flag |
                            (r_refresh_cnt >= REFRESH_DUE));

    // Frame register, handshake and idle refresh counter.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'h80;
            r_last_cmd    <= 4'b0000;
            r_refresh_cnt <= '0;
        end else if (w_xfer) begin
            r_tx_valid    <= 1'b0;
            r_last_cmd    <= r_tx_data[3:0];
            r_refresh_cnt <= '0;
        end else begin
            if (r_refresh_cnt != REFRESH_LAST) begin
                r_refresh_cnt <= r_refresh_cnt + 16'd1;
            end
            if (w_build) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= {2'b10, r_destroy_flag, w_frame_place, w_cmd};
            end
        end
    end

    // Sticky barrier flags; a same-cycle pulse wins over the clear on transfer.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_place_flag   <= 1'b0;
            r_destroy_flag <= 1'b0;
        end else begin
            r_place_flag   <= i_place_req | (r_place_flag & ~(w_xfer & r_tx_data[4]));
            r_destroy_flag <= i_destroy_req | (r_destroy_flag & ~(w_xfer & r_tx_data[5]));
        end
    end

    assign o_tx_valid       = r_tx_valid;
    assign o_tx_data        = r_tx_data;
    assign o_active_mode    = r_active_mode;
    assign o_grant          = r_grant;
    assign o_switch_pending = r_switch_pending;

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Directed bench for drive_mode_arbiter: power-up, mode switching with hold
// and retarget, reserved mode, UART back-pressure, barrier flags, refresh
// period and asynchronous reset mid-transaction.
`timescale 1ns/1ps
module tb_drive_mode_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       power;
    logic [1:0] mode_sel;
    logic [3:0] man_cmd, semi_cmd, auto_cmd;
    logic       semi_valid, auto_valid, place_req, destroy_req, tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] active_mode;
    logic [2:0] grant;
    logic       switch_pending;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] q_data[$];
    int         q_cyc[$];

    drive_mode_arbiter #(.SWITCH_HOLD(4), .REFRESH(8)) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_power(power), .i_mode_sel(mode_sel),
        .i_man_cmd(man_cmd), .i_semi_cmd(semi_cmd), .i_auto_cmd(auto_cmd),
        .i_semi_valid(semi_valid), .i_auto_valid(auto_valid),
        .i_place_req(place_req), .i_destroy_req(destroy_req), .i_tx_ready(tx_ready),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .o_active_mode(active_mode),
        .o_grant(grant), .o_switch_pending(switch_pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Log every accepted frame (valid & ready seen before the accepting edge).
    always @(negedge clk) begin
        if (tx_valid && tx_ready && !rst) begin
            q_data.push_back(tx_data);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        q_data.delete();
        q_cyc.delete();
    endtask

    // Advance until just after a transfer, leaving tx_valid low and the refresh counter at 0.
    task automatic sync_after_xfer;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (tx_valid && tx_ready) seen = 1'b1;
            tick(1);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL sync_xfer: got no transfer want one within 40 cycles"); end
    endtask

    task automatic test_reset;
        rst = 1'b1; power = 1'b0; mode_sel = 2'b00;
        man_cmd = 4'h0; semi_cmd = 4'h0; auto_cmd = 4'h0;
        semi_valid = 1'b0; auto_valid = 1'b0; place_req = 1'b0; destroy_req = 1'b0;
        tx_ready = 1'b1;
        tick(3);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h80) begin n_fail++; $display("FAIL reset_data: got %h want 80", tx_data); end
        n_checks++; if (active_mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", active_mode); end
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_checks++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b want 0", switch_pending); end
    endtask

    task automatic test_power_on;
        clear_log();
        rst = 1'b0; power = 1'b1; man_cmd = 4'h1;
        tick(1);
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL pwr_grant: got %b want 001", grant); end
        n_checks++; if (active_mode !== 2'b00) begin n_fail++; $display("FAIL pwr_mode: got %b want 00", active_mode); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL pwr_first_edge_valid: got %b want 0", tx_valid); end
        tick(1);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h81) begin n_fail++; $display("FAIL pwr_frame: got valid=%b data=%h want 1/81", tx_valid, tx_data); end
        tick(1);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL pwr_drop: got %b want 0", tx_valid); end
        n_checks++; if (q_data.size() != 1 || q_data[0] !== 8'h81) begin n_fail++; $display("FAIL pwr_log: got %0d frames want one 81", q_data.size()); end
    endtask

    task automatic test_mode_switch;
        man_cmd = 4'h2;
        tick(3);
        clear_log();
        mode_sel = 2'b10; auto_valid = 1'b1; auto_cmd = 4'h4;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++;
            if (switch_pending !== 1'b1 || grant !== 3'b000 || active_mode !== 2'b00) begin
                n_fail++; $display("FAIL sw_hold[%0d]: got pend=%b grant=%b mode=%b want 1/000/00", i, switch_pending, grant, active_mode);
            end
        end
        tick(1);
        n_checks++; if (switch_pending !== 1'b0 || grant !== 3'b100 || active_mode !== 2'b10) begin
            n_fail++; $display("FAIL sw_done: got pend=%b grant=%b mode=%b want 0/100/10", switch_pending, grant, active_mode);
        end
        tick(2);
        n_checks++; if (q_data.size() != 2) begin n_fail++; $display("FAIL sw_frames: got %0d frames want 2", q_data.size()); end
        else begin
            n_checks++; if (q_data[0] !== 8'h80 || q_data[1] !== 8'h84) begin n_fail++; $display("FAIL sw_frame_data: got %h %h want 80 84", q_data[0], q_data[1]); end
        end
    endtask

    task automatic test_switch_retarget;
        mode_sel = 2'b00;
        tick(5);
        n_checks++; if (active_mode !== 2'b00 || grant !== 3'b001 || switch_pending !== 1'b0) begin
            n_fail++; $display("FAIL rt_manual: got mode=%b grant=%b pend=%b want 00/001/0", active_mode, grant, switch_pending);
        end
        mode_sel = 2'b10;
        tick(3);
        mode_sel = 2'b01; semi_valid = 1'b1; semi_cmd = 4'h3;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++;
            if (switch_pending !== 1'b1 || active_mode !== 2'b00) begin
                n_fail++; $display("FAIL rt_hold[%0d]: got pend=%b mode=%b want 1/00", i, switch_pending, active_mode);
            end
        end
        tick(1);
        n_checks++; if (switch_pending !== 1'b0 || grant !== 3'b010 || active_mode !== 2'b01) begin
            n_fail++; $display("FAIL rt_semi: got pend=%b grant=%b mode=%b want 0/010/01", switch_pending, grant, active_mode);
        end
    endtask

    task automatic test_reserved;
        mode_sel = 2'b11;
        tick(6);
        n_checks++; if (switch_pending !== 1'b0 || grant !== 3'b010 || active_mode !== 2'b01) begin
            n_fail++; $display("FAIL rsvd: got pend=%b grant=%b mode=%b want 0/010/01", switch_pending, grant, active_mode);
        end
        mode_sel = 2'b01;
    endtask

    task automatic test_backpressure;
        tick(4);
        sync_after_xfer();
        clear_log();
        semi_cmd = 4'h5; tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h85) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h want 1/85", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        tick(1);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %b want 0", tx_valid); end
        n_checks++; if (q_data.size() != 1 || q_data[0] !== 8'h85) begin n_fail++; $display("FAIL bp_log: got %0d frames want one 85", q_data.size()); end
    endtask

    task automatic test_barrier;
        sync_after_xfer();
        clear_log();
        place_req = 1'b1; destroy_req = 1'b1;
        tick(1);
        place_req = 1'b0; destroy_req = 1'b0;
        tick(1);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL bar_destroy: got valid=%b data=%h want 1/a5", tx_valid, tx_data); end
        tick(2);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h95) begin n_fail++; $display("FAIL bar_place: got valid=%b data=%h want 1/95", tx_valid, tx_data); end
        place_req = 1'b1;
        tick(1);
        place_req = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL bar_xfer_drop: got %b want 0", tx_valid); end
        tick(1);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h95) begin n_fail++; $display("FAIL bar_sticky: got valid=%b data=%h want 1/95", tx_valid, tx_data); end
        tick(1);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL bar_final_drop: got %b want 0", tx_valid); end
        n_checks++; if (q_data.size() != 3) begin n_fail++; $display("FAIL bar_count: got %0d frames want 3", q_data.size()); end
        else begin
            n_checks++; if (q_data[0] !== 8'hA5 || q_data[1] !== 8'h95 || q_data[2] !== 8'h95) begin
                n_fail++; $display("FAIL bar_seq: got %h %h %h want a5 95 95", q_data[0], q_data[1], q_data[2]);
            end
        end
    endtask

    task automatic test_power_off;
        mode_sel = 2'b10;
        tick(2);
        n_checks++; if (switch_pending !== 1'b1) begin n_fail++; $display("FAIL off_in_switch: got %b want 1", switch_pending); end
        power = 1'b0;
        tick(1);
        n_checks++; if (grant !== 3'b000 || switch_pending !== 1'b0 || active_mode !== 2'b00) begin
            n_fail++; $display("FAIL off_state: got grant=%b pend=%b mode=%b want 000/0/00", grant, switch_pending, active_mode);
        end
        tick(12);
        clear_log();
        tick(34);
        n_checks++; if (q_data.size() < 4) begin n_fail++; $display("FAIL refresh_count: got %0d frames want >=4", q_data.size()); end
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++; if (q_data[i] !== 8'h80) begin n_fail++; $display("FAIL refresh_data[%0d]: got %h want 80", i, q_data[i]); end
        end
        for (int i = 1; i < q_cyc.size(); i++) begin
            n_checks++; if (q_cyc[i] - q_cyc[i-1] != 8) begin n_fail++; $display("FAIL refresh_period[%0d]: got %0d want 8", i, q_cyc[i] - q_cyc[i-1]); end
        end
    endtask

    task automatic test_rst_mid;
        clear_log();
        tx_ready = 1'b0; power = 1'b1;
        tick(1);
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL rm_manual_any_sel: got %b want 001", grant); end
        tick(1);
        n_checks++; if (switch_pending !== 1'b1 || tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL rm_busy: got pend=%b valid=%b want 1/1", switch_pending, tx_valid);
        end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h80) begin n_fail++; $display("FAIL rm_async_tx: got valid=%b data=%h want 0/80", tx_valid, tx_data); end
        n_checks++; if (switch_pending !== 1'b0 || grant !== 3'b000 || active_mode !== 2'b00) begin
            n_fail++; $display("FAIL rm_async_fsm: got pend=%b grant=%b mode=%b want 0/000/00", switch_pending, grant, active_mode);
        end
        power = 1'b0; tx_ready = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale: got %b want 0", tx_valid); end
        n_checks++; if (q_data.size() != 0) begin n_fail++; $display("FAIL rm_no_xfer: got %0d frames want 0", q_data.size()); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_mode_switch();
        test_switch_retarget();
        test_reserved();
        test_backpressure();
        test_barrier();
        test_power_off();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
